// File: rtl/rr_grant_dispatcher_pkg.sv
// Shared types and constant helpers for the round-robin grant dispatcher.
package rr_pkg;

    function automatic int unsigned idx_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    function automatic int unsigned cnt_max(input int unsigned cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } serve_state_t;

    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_HOLD = HOLD;

endpackage

// File: rtl/rr_grant_dispatcher_if.sv
// Client push, arbiter request/grant and downstream serve-slot signals.
interface rr_grant_dispatcher_if import rr_pkg::*; #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDX_W = idx_width(WIDTH)
);
    logic [WIDTH-1:0] push_vector;
    logic [WIDTH-1:0] push_ready;
    logic [WIDTH-1:0] req_vector;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_valid;
    logic             serve_valid;
    logic [IDX_W-1:0] serve_idx;
    logic             serve_ready;
    logic             busy;
    logic             overflow_err;
    logic             grant_err;

    modport master (
        output push_vector, grant_idx, grant_valid, serve_ready,
        input  push_ready, req_vector, serve_valid, serve_idx, busy,
               overflow_err, grant_err
    );

    modport slave (
        input  push_vector, grant_idx, grant_valid, serve_ready,
        output push_ready, req_vector, serve_valid, serve_idx, busy,
               overflow_err, grant_err
    );
endinterface

// File: rtl/rr_grant_dispatcher_pending_counter.sv
// Per-client saturating pending-request counter; never wraps in either direction.
module rr_pending_counter import rr_pkg::*; #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_count,
    output logic             o_nonzero,
    output logic             o_full,
    output logic             o_overflow
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

    logic [CNT_W-1:0] r_count;
    logic             w_inc;
    logic             w_dec;

    // Full is judged on the registered count, so a same-cycle decrement does not admit a push.
    assign o_full     = (r_count == CNT_MAX);
    assign o_nonzero  = (r_count != '0);
    assign w_inc      = i_inc && !o_full;
    assign w_dec      = i_dec && o_nonzero;
    assign o_overflow = i_inc && o_full;
    assign o_count    = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_inc && !w_dec) begin
            r_count <= r_count + CNT_W'(1);
        end else if (w_dec && !w_inc) begin
            r_count <= r_count - CNT_W'(1);
        end
    end
endmodule

// File: rtl/rr_grant_dispatcher.sv
// Books per-client pending requests, drives the arbiter request vector and
// dispatches each accepted grant through a single registered serve slot.
module rr_grant_dispatcher import rr_pkg::*; #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    rr_grant_dispatcher_if.slave bus
);
    localparam int unsigned IDX_W = idx_width(WIDTH);

    logic [CNT_W-1:0] w_count [WIDTH];
    logic [WIDTH-1:0] w_nonzero;
    logic [WIDTH-1:0] w_full;
    logic [WIDTH-1:0] w_overflow;
    logic [WIDTH-1:0] w_grant_hit;
    logic [WIDTH-1:0] w_dec;
    logic             w_slot_free;
    logic             w_grant_pending;
    logic             w_take;
    logic             w_grant_spurious;

    logic [0:0]       r_state;
    logic [IDX_W-1:0] r_serve_idx;
    logic             r_overflow_err;
    logic             r_grant_err;

    assign w_slot_free      = (r_state == ST_IDLE) || bus.serve_ready;
    assign w_grant_pending  = (w_count[bus.grant_idx] != '0);
    assign w_take           = bus.grant_valid && w_slot_free && w_grant_pending;
    assign w_grant_spurious = bus.grant_valid && w_slot_free && !w_grant_pending;
    assign w_dec            = w_grant_hit & {WIDTH{w_take}};

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_client
        assign w_grant_hit[gi] = (bus.grant_idx == IDX_W'(gi));

        rr_pending_counter #(
            .CNT_W (CNT_W)
        ) u_pending (
            .clk        (clk),
            .rst_n      (reset),
            .i_inc      (bus.push_vector[gi]),
            .i_dec      (w_dec[gi]),
            .o_count    (w_count[gi]),
            .o_nonzero  (w_nonzero[gi]),
            .o_full     (w_full[gi]),
            .o_overflow (w_overflow[gi])
        );
    end

    // A downstream accept and a new take in the same cycle keep the slot in HOLD.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_serve_idx <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_take) begin
                        r_state     <= ST_HOLD;
                        r_serve_idx <= bus.grant_idx;
                    end
                end
                ST_HOLD: begin
                    if (bus.serve_ready) begin
                        if (w_take) begin
                            r_serve_idx <= bus.grant_idx;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow_err <= 1'b0;
            r_grant_err    <= 1'b0;
        end else begin
            r_overflow_err <= r_overflow_err | (|w_overflow);
            r_grant_err    <= r_grant_err | w_grant_spurious;
        end
    end

    assign bus.push_ready   = ~w_full;
    assign bus.req_vector   = w_nonzero & {WIDTH{w_slot_free}};
    assign bus.serve_valid  = (r_state == ST_HOLD);
    assign bus.serve_idx    = r_serve_idx;
    assign bus.busy         = (|w_nonzero) || (r_state == ST_HOLD);
    assign bus.overflow_err = r_overflow_err;
    assign bus.grant_err    = r_grant_err;
endmodule

// File: tb/tb_rr_grant_dispatcher.sv
// Scoreboard bench for rr_grant_dispatcher: a behavioural pending/slot model
// predicts outputs; granted indices are queued and matched against serve_idx.
module tb_rr_grant_dispatcher;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;
    localparam int          MAXP  = 15;

    logic clk;
    logic reset;

    int unsigned vectors;
    int unsigned miscompares;

    int         m_pend [WIDTH];
    logic       m_sv;
    logic       m_ovf;
    logic       m_gerr;
    logic [2:0] exp_q [$];

    rr_grant_dispatcher_if #(.WIDTH(WIDTH)) bus ();

    rr_grant_dispatcher #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] exp_req();
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) r[i] = (m_pend[i] != 0) && (!m_sv || bus.serve_ready);
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] exp_ready();
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) r[i] = (m_pend[i] != MAXP);
        return r;
    endfunction

    function automatic logic exp_busy();
        logic b;
        b = m_sv;
        for (int i = 0; i < WIDTH; i++) if (m_pend[i] != 0) b = 1'b1;
        return b;
    endfunction

    function automatic logic [2:0] exp_front();
        return (exp_q.size() != 0) ? exp_q[0] : 3'bxxx;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < WIDTH; i++) m_pend[i] = 0;
        m_sv   = 1'b0;
        m_ovf  = 1'b0;
        m_gerr = 1'b0;
        exp_q.delete();
    endtask

    task automatic drive_idle();
        bus.push_vector = '0;
        bus.grant_valid = 1'b0;
        bus.grant_idx   = '0;
        bus.serve_ready = 1'b0;
    endtask

    task automatic apply_reset();
        drive_idle();
        reset = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Advances one clock: predicts the next state from the current inputs,
    // queues accepted grants, retires handshaken ones, then clears the pulses.
    task automatic cycle();
        logic       sf;
        logic       take;
        logic [2:0] g;
        int         nxt [WIDTH];
        g    = bus.grant_idx;
        sf   = !m_sv || bus.serve_ready;
        take = bus.grant_valid && sf && (m_pend[g] != 0);
        if (bus.grant_valid && sf && (m_pend[g] == 0)) m_gerr = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            nxt[i] = m_pend[i];
            if (bus.push_vector[i]) begin
                if (m_pend[i] == MAXP) m_ovf = 1'b1;
                else nxt[i] = nxt[i] + 1;
            end
            if (take && (g == 3'(i))) nxt[i] = nxt[i] - 1;
        end
        if (m_sv && bus.serve_ready && (exp_q.size() != 0)) void'(exp_q.pop_front());
        if (take) exp_q.push_back(g);
        m_sv = take || (m_sv && !bus.serve_ready);
        @(posedge clk);
        m_pend = nxt;
        #1;
        bus.push_vector = '0;
        bus.grant_valid = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        model_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (bus.req_vector !== 8'h00) begin miscompares++; $display("FAIL reset_req_vector: got %h expected %h", bus.req_vector, 8'h00); end
        vectors++; if (bus.push_ready !== 8'hFF) begin miscompares++; $display("FAIL reset_push_ready: got %h expected %h", bus.push_ready, 8'hFF); end
        vectors++; if (bus.serve_valid !== 1'b0) begin miscompares++; $display("FAIL reset_serve_valid: got %b expected 0", bus.serve_valid); end
        vectors++; if (bus.serve_idx !== 3'd0) begin miscompares++; $display("FAIL reset_serve_idx: got %0d expected 0", bus.serve_idx); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        vectors++; if (bus.overflow_err !== 1'b0) begin miscompares++; $display("FAIL reset_overflow_err: got %b expected 0", bus.overflow_err); end
        vectors++; if (bus.grant_err !== 1'b0) begin miscompares++; $display("FAIL reset_grant_err: got %b expected 0", bus.grant_err); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        vectors++; if (bus.push_ready !== exp_ready()) begin miscompares++; $display("FAIL idle_push_ready: got %h expected %h", bus.push_ready, exp_ready()); end
    endtask

    task automatic test_single_grant();
        bus.push_vector = 8'h01;
        cycle();
        vectors++; if (bus.req_vector !== exp_req()) begin miscompares++; $display("FAIL push0_req_vector: got %h expected %h", bus.req_vector, exp_req()); end
        vectors++; if (bus.busy !== exp_busy()) begin miscompares++; $display("FAIL push0_busy: got %b expected %b", bus.busy, exp_busy()); end
        bus.serve_ready = 1'b1;
        bus.grant_idx   = 3'd0;
        bus.grant_valid = 1'b1;
        cycle();
        vectors++; if (bus.serve_valid !== m_sv) begin miscompares++; $display("FAIL single_serve_valid: got %b expected %b", bus.serve_valid, m_sv); end
        vectors++; if (bus.serve_idx !== exp_front()) begin miscompares++; $display("FAIL single_serve_idx: got %0d expected %0d", bus.serve_idx, exp_front()); end
        vectors++; if (bus.req_vector !== exp_req()) begin miscompares++; $display("FAIL single_req_vector: got %h expected %h", bus.req_vector, exp_req()); end
        cycle();
        vectors++; if (bus.serve_valid !== m_sv) begin miscompares++; $display("FAIL single_drain_valid: got %b expected %b", bus.serve_valid, m_sv); end
        vectors++; if (bus.busy !== exp_busy()) begin miscompares++; $display("FAIL single_drain_busy: got %b expected %b", bus.busy, exp_busy()); end
    endtask

    task automatic test_backpressure();
        bus.push_vector = 8'b0000_1010;
        cycle();
        bus.serve_ready = 1'b0;
        #1;
        vectors++; if (bus.req_vector !== exp_req()) begin miscompares++; $display("FAIL bp_req_initial: got %h expected %h", bus.req_vector, exp_req()); end
        bus.grant_idx   = 3'd1;
        bus.grant_valid = 1'b1;
        cycle();
        vectors++; if (bus.serve_valid !== m_sv) begin miscompares++; $display("FAIL bp_serve_valid: got %b expected %b", bus.serve_valid, m_sv); end
        vectors++; if (bus.serve_idx !== exp_front()) begin miscompares++; $display("FAIL bp_serve_idx1: got %0d expected %0d", bus.serve_idx, exp_front()); end
        bus.grant_idx   = 3'd3;
        bus.grant_valid = 1'b1;
        #1;
        vectors++; if (bus.req_vector !== exp_req()) begin miscompares++; $display("FAIL bp_req_stalled: got %h expected %h", bus.req_vector, exp_req()); end
        cycle();
        vectors++; if (bus.serve_idx !== exp_front()) begin miscompares++; $display("FAIL bp_idx_held: got %0d expected %0d", bus.serve_idx, exp_front()); end
        vectors++; if (bus.grant_err !== m_gerr) begin miscompares++; $display("FAIL bp_no_grant_err: got %b expected %b", bus.grant_err, m_gerr); end
        bus.serve_ready = 1'b1;
        #1;
        vectors++; if (bus.req_vector !== exp_req()) begin miscompares++; $display("FAIL bp_req_released: got %h expected %h", bus.req_vector, exp_req()); end
        vectors++; if (bus.serve_idx !== exp_front()) begin miscompares++; $display("FAIL bp_handoff_idx: got %0d expected %0d", bus.serve_idx, exp_front()); end
        bus.grant_idx   = 3'd3;
        bus.grant_valid = 1'b1;
        cycle();
        vectors++; if (bus.serve_valid !== m_sv) begin miscompares++; $display("FAIL bp_regrant_valid: got %b expected %b", bus.serve_valid, m_sv); end
        vectors++; if (bus.serve_idx !== exp_front()) begin miscompares++; $display("FAIL bp_regrant_idx: got %0d expected %0d", bus.serve_idx, exp_front()); end
        cycle();
        vectors++; if (bus.serve_valid !== m_sv) begin miscompares++; $display("FAIL bp_drain_valid: got %b expected %b", bus.serve_valid, m_sv); end
        vectors++; if (bus.busy !== exp_busy()) begin miscompares++; $display("FAIL bp_drain_busy: got %b expected %b", bus.busy, exp_busy()); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] seq [3];
        seq = '{3'd0, 3'd4, 3'd7};
        bus.push_vector = 8'b1001_0001;
        cycle();
        bus.serve_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.grant_idx   = seq[k];
            bus.grant_valid = 1'b1;
            cycle();
            vectors++; if (bus.serve_valid !== m_sv) begin miscompares++; $display("FAIL b2b_valid[%0d]: got %b expected %b", k, bus.serve_valid, m_sv); end
            vectors++; if (bus.serve_idx !== exp_front()) begin miscompares++; $display("FAIL b2b_idx[%0d]: got %0d expected %0d", k, bus.serve_idx, exp_front()); end
        end
        cycle();
        vectors++; if (bus.serve_valid !== m_sv) begin miscompares++; $display("FAIL b2b_drain_valid: got %b expected %b", bus.serve_valid, m_sv); end
        vectors++; if (bus.busy !== exp_busy()) begin miscompares++; $display("FAIL b2b_drain_busy: got %b expected %b", bus.busy, exp_busy()); end
    endtask

    task automatic test_full_take();
        apply_reset();
        for (int k = 0; k < MAXP; k++) begin
            bus.push_vector = 8'h20;
            cycle();
        end
        vectors++; if (bus.push_ready !== exp_ready()) begin miscompares++; $display("FAIL full5_push_ready: got %h expected %h", bus.push_ready, exp_ready()); end
        bus.serve_ready = 1'b1;
        bus.push_vector = 8'h20;
        bus.grant_idx   = 3'd5;
        bus.grant_valid = 1'b1;
        cycle();
        vectors++; if (bus.push_ready !== exp_ready()) begin miscompares++; $display("FAIL fulltake_push_ready: got %h expected %h", bus.push_ready, exp_ready()); end
        vectors++; if (bus.overflow_err !== m_ovf) begin miscompares++; $display("FAIL fulltake_overflow: got %b expected %b", bus.overflow_err, m_ovf); end
        vectors++; if (bus.serve_valid !== m_sv) begin miscompares++; $display("FAIL fulltake_valid: got %b expected %b", bus.serve_valid, m_sv); end
        vectors++; if (bus.serve_idx !== exp_front()) begin miscompares++; $display("FAIL fulltake_idx: got %0d expected %0d", bus.serve_idx, exp_front()); end
        bus.push_vector = 8'h20;
        cycle();
        vectors++; if (bus.push_ready !== exp_ready()) begin miscompares++; $display("FAIL refill_push_ready: got %h expected %h", bus.push_ready, exp_ready()); end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int k = 0; k < 16; k++) begin
            bus.push_vector = 8'h04;
            cycle();
            vectors++; if (bus.push_ready !== exp_ready()) begin miscompares++; $display("FAIL ovf_push_ready[%0d]: got %h expected %h", k, bus.push_ready, exp_ready()); end
            vectors++; if (bus.overflow_err !== m_ovf) begin miscompares++; $display("FAIL ovf_flag[%0d]: got %b expected %b", k, bus.overflow_err, m_ovf); end
        end
        cycle();
        vectors++; if (bus.overflow_err !== m_ovf) begin miscompares++; $display("FAIL ovf_sticky: got %b expected %b", bus.overflow_err, m_ovf); end
    endtask

    task automatic test_spurious_and_reset();
        bus.serve_ready = 1'b1;
        bus.grant_idx   = 3'd6;
        bus.grant_valid = 1'b1;
        cycle();
        vectors++; if (bus.grant_err !== m_gerr) begin miscompares++; $display("FAIL spurious_grant_err: got %b expected %b", bus.grant_err, m_gerr); end
        vectors++; if (bus.serve_valid !== m_sv) begin miscompares++; $display("FAIL spurious_serve_valid: got %b expected %b", bus.serve_valid, m_sv); end
        bus.serve_ready = 1'b0;
        bus.grant_idx   = 3'd2;
        bus.grant_valid = 1'b1;
        cycle();
        vectors++; if (bus.serve_valid !== m_sv) begin miscompares++; $display("FAIL hold_serve_valid: got %b expected %b", bus.serve_valid, m_sv); end
        vectors++; if (bus.serve_idx !== exp_front()) begin miscompares++; $display("FAIL hold_serve_idx: got %0d expected %0d", bus.serve_idx, exp_front()); end
        #2;
        reset = 1'b0;
        #1;
        vectors++; if (bus.serve_valid !== 1'b0) begin miscompares++; $display("FAIL midreset_serve_valid: got %b expected 0", bus.serve_valid); end
        vectors++; if (bus.serve_idx !== 3'd0) begin miscompares++; $display("FAIL midreset_serve_idx: got %0d expected 0", bus.serve_idx); end
        vectors++; if (bus.push_ready !== 8'hFF) begin miscompares++; $display("FAIL midreset_push_ready: got %h expected %h", bus.push_ready, 8'hFF); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL midreset_busy: got %b expected 0", bus.busy); end
        vectors++; if (bus.overflow_err !== 1'b0) begin miscompares++; $display("FAIL midreset_overflow_err: got %b expected 0", bus.overflow_err); end
        vectors++; if (bus.grant_err !== 1'b0) begin miscompares++; $display("FAIL midreset_grant_err: got %b expected 0", bus.grant_err); end
        drive_idle();
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 300; c++) begin
            bus.push_vector = 8'($urandom & $urandom);
            bus.grant_valid = ($urandom_range(0, 3) != 0);
            bus.grant_idx   = 3'($urandom_range(0, 7));
            bus.serve_ready = ($urandom_range(0, 3) != 0);
            #1;
            vectors++; if (bus.req_vector !== exp_req()) begin miscompares++; $display("FAIL rnd_req_vector[%0d]: got %h expected %h", c, bus.req_vector, exp_req()); end
            if (m_sv) begin
                vectors++; if (bus.serve_idx !== exp_front()) begin miscompares++; $display("FAIL rnd_serve_idx[%0d]: got %0d expected %0d", c, bus.serve_idx, exp_front()); end
            end
            cycle();
            vectors++; if (bus.serve_valid !== m_sv) begin miscompares++; $display("FAIL rnd_serve_valid[%0d]: got %b expected %b", c, bus.serve_valid, m_sv); end
            vectors++; if (bus.push_ready !== exp_ready()) begin miscompares++; $display("FAIL rnd_push_ready[%0d]: got %h expected %h", c, bus.push_ready, exp_ready()); end
            vectors++; if (bus.busy !== exp_busy()) begin miscompares++; $display("FAIL rnd_busy[%0d]: got %b expected %b", c, bus.busy, exp_busy()); end
            vectors++; if (bus.overflow_err !== m_ovf) begin miscompares++; $display("FAIL rnd_overflow[%0d]: got %b expected %b", c, bus.overflow_err, m_ovf); end
            vectors++; if (bus.grant_err !== m_gerr) begin miscompares++; $display("FAIL rnd_grant_err[%0d]: got %b expected %b", c, bus.grant_err, m_gerr); end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single_grant();
        test_backpressure();
        test_back_to_back();
        test_full_take();
        test_overflow();
        test_spurious_and_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
